mod_exp_ctrl: RTL

MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/mod_exp_ctrl_if.sv | 31 +++
 rtl/mod_exp_ctrl_mod.sv | 16 +
 rtl/mod_exp_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg -- shared definitions for the modular-exponentiation controller.
//   state_t         : FSM state encoding of mod_exp_ctrl
//   mod_exp_latency : cycles from the start-accept edge until done is high
//                     for a nonzero modulus
// ---------------------------------------------------------------------------
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        LRED = 3'd2,
        SQR  = 3'd3,
        SRED = 3'd4,
        MUL  = 3'd5,
        MRED = 3'd6,
        DONE = 3'd7
    } state_t;

    // Every exponent bit costs a square and its reduction. Every set bit adds
    // a multiply and its reduction. Base loading and reduction add two cycles.
    function automatic int unsigned mod_exp_latency(input int unsigned width,
                                                    input int unsigned exp_ones);
        return 2 + 2 * width + 2 * exp_ones;
    endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// ---------------------------------------------------------------------------
// mod_exp_ctrl_if -- job/handshake bundle of the modular-exponentiation unit.
//   start                : request a job (requester -> engine)
//   base, exp, modulus   : operands, captured when start is accepted
//   busy                 : engine is not idle
//   done                 : one-cycle completion pulse
//   result, err          : base^exp mod modulus, and the zero-modulus flag
// master = requester side, slave = engine side.
// ---------------------------------------------------------------------------
interface mod_exp_ctrl_if #(
    parameter int WIDTH = 256
) ();
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, base, exp, modulus,
        input  busy, done, result, err
    );

    modport slave (
        input  start, base, exp, modulus,
        output busy, done, result, err
    );
endinterface

// File: rtl/mod_exp_ctrl_mod.sv
// ---------------------------------------------------------------------------
// mod -- combinational remainder unit: remainder = dividend mod divisor.
//   dividend  : WIDTH-bit numerator
//   divisor   : WIDTH-bit denominator. A zero divisor yields a zero remainder.
//   remainder : WIDTH-bit result
// ---------------------------------------------------------------------------
module mod #(
    parameter int WIDTH = 512
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder
);
    // The guard keeps the output defined while the controller idles with n=0.
    assign remainder = (divisor == '0) ? '0 : (dividend % divisor);
endmodule

// File: rtl/mod_exp_ctrl.sv
// ---------------------------------------------------------------------------
// mod_exp_ctrl -- sequential modular exponentiation, result = base^exp mod n.
// The engine uses left-to-right square-and-multiply over all WIDTH exponent
// bits. One multiplier and one remainder unit are shared by all steps.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mod_exp_ctrl_if.slave (start/operands in, busy/done/result/err out)
// ---------------------------------------------------------------------------
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_exp_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef logic [IW-1:0]      idx_t;
    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [2*WIDTH-1:0] dword_t;

    state_t state_q, state_d;
    word_t  acc_q, acc_d;
    word_t  base_r_q, base_r_d;
    word_t  exp_q, exp_d;
    word_t  n_q, n_d;
    word_t  result_q, result_d;
    dword_t prod_q, prod_d;
    idx_t   i_q, i_d;
    logic   err_q, err_d;

    word_t  mul_b;
    dword_t mul_p;
    dword_t rem;
    word_t  rem_lo;
    word_t  rem_hi_unused;
    logic   last_bit;

    // The second multiplier operand is base_r only in MUL. Otherwise it is
    // acc, which squares the accumulator in SQR.
    assign mul_b = (state_q == MUL) ? base_r_q : acc_q;
    // Operands are widened so the full 2*WIDTH-bit product is kept.
    assign mul_p = dword_t'(acc_q) * dword_t'(mul_b);

    mod #(
        .WIDTH (2 * WIDTH)
    ) u_mod (
        .dividend  (prod_q),
        .divisor   ({{WIDTH{1'b0}}, n_q}),
        .remainder (rem)
    );

    // The remainder is below n, so the upper half is always zero.
    assign {rem_hi_unused, rem_lo} = rem;
    assign last_bit = (i_q == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: state_d gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = (bus.modulus == '0) ? DONE : LOAD;
            LOAD: state_d = LRED;
            LRED: state_d = SQR;
            SQR:  state_d = SRED;
            SRED: begin
                if (exp_q[i_q]) state_d = MUL;
                else            state_d = last_bit ? DONE : SQR;
            end
            MUL:  state_d = MRED;
            MRED: state_d = last_bit ? DONE : SQR;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    assign bus.result = result_q;
    assign bus.err    = err_q;

    // Datapath next-state logic.
    always_comb begin
        acc_d    = acc_q;
        prod_d   = prod_q;
        base_r_d = base_r_q;
        exp_d    = exp_q;
        n_d      = n_q;
        i_d      = i_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_r_d = bus.base;
                    exp_d    = bus.exp;
                    n_d      = bus.modulus;
                    if (bus.modulus == '0) begin
                        acc_d    = '0;
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        acc_d = word_t'(1);
                        err_d = 1'b0;
                    end
                end
            end
            LOAD: prod_d = dword_t'(base_r_q);
            LRED: begin
                base_r_d = rem_lo;
                i_d      = idx_t'(WIDTH - 1);
            end
            SQR, MUL: prod_d = mul_p;
            SRED, MRED: begin
                acc_d = rem_lo;
                // The result is loaded on entry to DONE, so it is already
                // valid while done is high.
                if (state_d == DONE)     result_d = rem_lo;
                else if (state_d == SQR) i_d = i_q - idx_t'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            prod_q   <= '0;
            base_r_q <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            base_r_q <= base_r_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            i_q      <= i_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
endmodule
